// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner and its code FIFO.
package keypad_pkg;

  localparam int KEY_W    = 4;
  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  typedef enum logic [1:0] {IDLE, CAND, PRESSED, REL} key_state_t;

  typedef struct packed {
    logic             valid;
    logic [KEY_W-1:0] code;
  } frame_key_t;

  localparam frame_key_t NO_KEY = '{valid: 1'b0, code: '0};

endpackage

// File: rtl/key_fifo.sv
// Show-ahead synchronous FIFO: dout is a registered copy of the head entry.
module key_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_inc;
  logic [PW:0]   count_reg;
  logic [W-1:0]  dout_reg;
  logic          push_ok, pop_ok;

  assign empty      = (count_reg == '0);
  assign full       = (count_reg == (PW+1)'(DEPTH));
  assign pop_ok     = pop & ~empty;
  assign push_ok    = push & (~full | pop_ok);
  assign rd_ptr_inc = rd_ptr_reg + PW'(1);
  assign dout       = dout_reg;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      dout_reg   <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_inc;
      count_reg <= count_reg + (PW+1)'(push_ok) - (PW+1)'(pop_ok);
      // Head register: new entry when empty, else the next stored entry on a pop.
      if (empty && push_ok) begin
        dout_reg <= din;
      end else if (pop_ok) begin
        if (count_reg == (PW+1)'(1)) begin
          if (push_ok) dout_reg <= din;
        end else begin
          dout_reg <= mem[rd_ptr_inc];
        end
      end
    end
  end

endmodule

// File: rtl/keypad_scan_fifo.sv
// 4x4 keypad scanner with per-frame debounce feeding a show-ahead code FIFO.
// Optional auto-repeat while a key is held is built when KEYPAD_REPEAT_EN is defined.
module keypad_scan_fifo
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV      = 1000,
  parameter int DEBOUNCE      = 4,
  parameter int FIFO_DEPTH    = 4,
  parameter int REPEAT_FRAMES = 50
) (
  input  logic             clk,
  input  logic             rst,
  output logic [3:0]       rows,
  input  logic [3:0]       cols,
  input  logic             rd_en,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  output logic             overflow,
  input  logic             overflow_clr
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE + 1);

  if (SCAN_DIV < 2 || DEBOUNCE < 1 || REPEAT_FRAMES < 1 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
    $error("keypad_scan_fifo: illegal parameter value");
  end

  logic [DIV_W-1:0] div_reg;
  logic [1:0]       row_reg;
  frame_key_t       acc_reg, row_key, scan_key;
  logic             sample_tick, frame_done;

  key_state_t       state_reg, state_next;
  logic [KEY_W-1:0] cand_reg, cand_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             push;
  logic             overflow_reg;
  logic             fifo_empty, fifo_full;

  assign sample_tick = (div_reg == DIV_W'(SCAN_DIV - 1));
  assign frame_done  = sample_tick && (row_reg == 2'd3);
  assign rows        = ~(4'b0001 << row_reg);

  // Lowest active column on the current row; rows earlier in the frame take priority.
  always_comb begin
    row_key = NO_KEY;
    for (int c = NUM_COLS - 1; c >= 0; c--) begin
      if (!cols[c]) row_key = '{valid: 1'b1, code: {row_reg, 2'(c)}};
    end
    scan_key = (row_reg != 2'd0 && acc_reg.valid) ? acc_reg : row_key;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_reg <= '0;
      row_reg <= '0;
      acc_reg <= NO_KEY;
    end else begin
      div_reg <= sample_tick ? '0 : div_reg + DIV_W'(1);
      if (sample_tick) begin
        row_reg <= row_reg + 2'd1;
        acc_reg <= scan_key;
      end
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_FRAMES + 1);
  logic [REP_W-1:0] rep_reg, rep_next;
`endif

  always_comb begin
    state_next = state_reg;
    cand_next  = cand_reg;
    cnt_next   = cnt_reg;
    push       = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_next   = rep_reg;
`endif
    if (frame_done) begin
      case (state_reg)
        IDLE: if (scan_key.valid) begin
          cand_next = scan_key.code;
          cnt_next  = CNT_W'(1);
          if (DEBOUNCE <= 1) begin
            push       = 1'b1;
            state_next = PRESSED;
`ifdef KEYPAD_REPEAT_EN
            rep_next   = '0;
`endif
          end else begin
            state_next = CAND;
          end
        end
        CAND: begin
          if (!scan_key.valid) begin
            state_next = IDLE;
          end else if (scan_key.code == cand_reg) begin
            cnt_next = cnt_reg + CNT_W'(1);
            if (int'(cnt_reg) + 1 >= DEBOUNCE) begin
              push       = 1'b1;
              state_next = PRESSED;
`ifdef KEYPAD_REPEAT_EN
              rep_next   = '0;
`endif
            end
          end else begin
            cand_next = scan_key.code;
            cnt_next  = CNT_W'(1);
          end
        end
        PRESSED: begin
          if (!scan_key.valid) begin
            cnt_next   = CNT_W'(1);
            state_next = (DEBOUNCE <= 1) ? IDLE : REL;
          end
`ifdef KEYPAD_REPEAT_EN
          else if (scan_key.code == cand_reg) begin
            if (int'(rep_reg) + 1 >= REPEAT_FRAMES) begin
              push     = 1'b1;
              rep_next = '0;
            end else begin
              rep_next = rep_reg + REP_W'(1);
            end
          end
`endif
        end
        REL: begin
          if (scan_key.valid) begin
            state_next = PRESSED;
`ifdef KEYPAD_REPEAT_EN
            rep_next   = '0;
`endif
          end else if (int'(cnt_reg) + 1 >= DEBOUNCE) begin
            state_next = IDLE;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cand_reg  <= '0;
      cnt_reg   <= '0;
`ifdef KEYPAD_REPEAT_EN
      rep_reg   <= '0;
`endif
    end else begin
      state_reg <= state_next;
      cand_reg  <= cand_next;
      cnt_reg   <= cnt_next;
`ifdef KEYPAD_REPEAT_EN
      rep_reg   <= rep_next;
`endif
    end
  end

  key_fifo #(.DEPTH(FIFO_DEPTH), .W(KEY_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (cand_next),
    .pop   (rd_en),
    .dout  (key_code),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // A full FIFO can only absorb a push when a pop lands in the same cycle.
  always_ff @(posedge clk) begin
    if (rst)                           overflow_reg <= 1'b0;
    else if (push && fifo_full && !rd_en) overflow_reg <= 1'b1;
    else if (overflow_clr)             overflow_reg <= 1'b0;
  end

  assign key_valid = ~fifo_empty;
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Frame-level bench for keypad_scan_fifo: directed scenarios then random key
// traffic, checked against a run-length debounce model and a queue FIFO.
module tb_keypad_scan_fifo;

  localparam int SCAN_DIV      = 4;
  localparam int DEBOUNCE      = 3;
  localparam int FIFO_DEPTH    = 4;
  localparam int REPEAT_FRAMES = 2;
  localparam int FRAME         = 4 * SCAN_DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] rows, cols;
  logic       rd_en = 1'b0, overflow_clr = 1'b0;
  logic [3:0] key_code;
  logic       key_valid, overflow;
  logic [15:0] key_mask = '0;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int q[$];
  bit ovf_m, held, gap;
  int run_key, run_len, acc_key, rep;

  keypad_scan_fifo #(
    .SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE),
    .FIFO_DEPTH(FIFO_DEPTH), .REPEAT_FRAMES(REPEAT_FRAMES)
  ) dut (
    .clk(clk), .rst(rst), .rows(rows), .cols(cols), .rd_en(rd_en),
    .key_code(key_code), .key_valid(key_valid), .overflow(overflow),
    .overflow_clr(overflow_clr)
  );

  always #5 clk = ~clk;

  // Key matrix: a pressed key shorts its column low while its row is driven.
  always_comb begin
    cols = 4'hF;
    for (int r = 0; r < 4; r++)
      if (!rows[r]) cols = cols & ~key_mask[r*4 +: 4];
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int frame_key(input logic [15:0] m);
    for (int i = 0; i < 16; i++) if (m[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    q.delete();
    ovf_m = 0; held = 0; gap = 0;
    run_key = -2; run_len = 0; acc_key = -1; rep = 0;
  endtask

  task automatic model_push(input int k);
    if (q.size() == FIFO_DEPTH) ovf_m = 1;
    else q.push_back(k);
  endtask

  // A press is accepted after DEBOUNCE identical key frames, a release after
  // DEBOUNCE empty frames; anything shorter is bounce.
  task automatic model_frame(input int k);
    if (k == run_key) run_len++;
    else begin run_key = k; run_len = 1; end
    if (!held) begin
      if (k >= 0 && run_len == DEBOUNCE) begin
        model_push(k);
        held = 1; acc_key = k; rep = 0; gap = 0;
      end
    end else if (k < 0) begin
      gap = 1;
      if (run_len == DEBOUNCE) held = 0;
    end else if (gap) begin
      gap = 0; rep = 0;
    end else if (k == acc_key) begin
`ifdef KEYPAD_REPEAT_EN
      rep++;
      if (rep == REPEAT_FRAMES) begin model_push(k); rep = 0; end
`endif
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_valid"}, key_valid, q.size() != 0);
    chk({tag, "_ovf"}, overflow, ovf_m);
    if (q.size() != 0) chk({tag, "_code"}, key_code, q[0]);
  endtask

  // One scan frame; optional pop mid-frame and overflow clear early in the frame.
  task automatic run_frame(input string tag, input logic [15:0] m, input bit pop, input bit clr);
    key_mask = m;
    for (int i = 0; i < FRAME; i++) begin
      if (pop && i == 7) rd_en = 1'b1;
      if (clr && i == 3) overflow_clr = 1'b1;
      @(posedge clk); #1;
      rd_en = 1'b0;
      overflow_clr = 1'b0;
    end
    if (pop && q.size() != 0) void'(q.pop_front());
    if (clr) ovf_m = 0;
    model_frame(frame_key(m));
    check_outputs(tag);
  endtask

  task automatic press_release(input string tag, input logic [15:0] m, input bit pop_first);
    for (int f = 0; f < DEBOUNCE; f++) run_frame(tag, m, 1'b0, 1'b0);
    for (int f = 0; f < DEBOUNCE; f++) run_frame(tag, '0, pop_first && f == 0, 1'b0);
  endtask

  initial begin
    logic [15:0] m;
    int len;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rows", rows, 4'b1110);
    chk("rst_valid", key_valid, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_code", key_code, 4'h0);
    rst = 1'b0;

    // Row walk
    repeat (SCAN_DIV) @(posedge clk);
    #1 chk("row1", rows, 4'b1101);
    repeat (FRAME - SCAN_DIV) @(posedge clk);
    #1 chk("row_wrap", rows, 4'b1110);
    model_frame(-1);
    check_outputs("idle");
    $display("step reset/scan done, checks=%0d", n_checks);

    // Held row2/col1: single push, latency check on the third frame
    m = 16'h0200;
    run_frame("k9_f1", m, 1'b0, 1'b0);
    run_frame("k9_f2", m, 1'b0, 1'b0);
    key_mask = m;
    repeat (FRAME - 1) @(posedge clk);
    #1 chk("k9_pre", key_valid, 1'b0);
    @(posedge clk); #1;
    model_frame(frame_key(m));
    check_outputs("k9_f3");
    chk("k9_code", key_code, 4'd9);
    run_frame("k9_f4", m, 1'b0, 1'b0);
    run_frame("k9_f5", m, 1'b0, 1'b0);
    run_frame("k9_pop", '0, 1'b1, 1'b0);
    chk("k9_empty", key_valid, 1'b0);
    run_frame("k9_rel", '0, 1'b0, 1'b0);
    run_frame("k9_rel", '0, 1'b0, 1'b0);
    $display("step single press done, checks=%0d", n_checks);

    // Bounce on key 0
    m = 16'h0001;
    run_frame("bnc", m, 1'b0, 1'b0);
    run_frame("bnc", m, 1'b0, 1'b0);
    run_frame("bnc", '0, 1'b0, 1'b0);
    run_frame("bnc", m, 1'b0, 1'b0);
    run_frame("bnc", m, 1'b0, 1'b0);
    chk("bnc_nopush", key_valid, 1'b0);
    run_frame("bnc_f3", m, 1'b0, 1'b0);
    chk("bnc_code", key_code, 4'd0);
    for (int f = 0; f < DEBOUNCE; f++) run_frame("bnc_rel", '0, f == 0, 1'b0);
    $display("step bounce done, checks=%0d", n_checks);

    // Ghost: row0/col3 plus row1/col0 resolves to 3
    press_release("ghost", 16'h0018, 1'b0);
    chk("ghost_code", key_code, 4'd3);
    run_frame("ghost_pop", '0, 1'b1, 1'b0);
    $display("step multi-key done, checks=%0d", n_checks);

    // Overflow: five presses, no reads
    for (int k = 1; k <= 5; k++) press_release("ovf_fill", 16'(1) << k, 1'b0);
    chk("ovf_set", overflow, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      chk("ovf_read", key_code, k);
      run_frame("ovf_pop", '0, 1'b1, 1'b0);
    end
    chk("ovf_drained", key_valid, 1'b0);
    run_frame("ovf_clr", '0, 1'b0, 1'b1);
    chk("ovf_cleared", overflow, 1'b0);
    $display("step overflow done, checks=%0d", n_checks);

    // Reset during candidate count 2 of key 7, then fresh hold
    m = 16'h0080;
    run_frame("rstc", m, 1'b0, 1'b0);
    run_frame("rstc", m, 1'b0, 1'b0);
    key_mask = m;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    model_reset();
    chk("rstc_rows", rows, 4'b1110);
    chk("rstc_valid", key_valid, 1'b0);
    rst = 1'b0;
    run_frame("rstc_h1", m, 1'b0, 1'b0);
    run_frame("rstc_h2", m, 1'b0, 1'b0);
    chk("rstc_nopush", key_valid, 1'b0);
    for (int f = 3; f <= 7; f++) run_frame("rstc_hold", m, 1'b0, 1'b0);
    chk("rstc_code", key_code, 4'd7);
    for (int f = 0; f < DEBOUNCE; f++) run_frame("rstc_rel", '0, 1'b1, 1'b0);
    $display("step reset-abort done, checks=%0d", n_checks);

    // Random traffic: runs of random key patterns, random pops and clears
    for (int s = 0; s < 40; s++) begin
      case ($urandom_range(0, 3))
        0: m = '0;
        1, 2: m = 16'(1) << $urandom_range(0, 15);
        default: m = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
      endcase
      len = $urandom_range(1, 5);
      for (int j = 0; j < len; j++)
        run_frame("rand", m, $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
    end
    $display("step random done, checks=%0d", n_checks);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
